// File: rtl/mdio_apb_bridge.sv
// MDIO request port to apbmapper bridge: 4-register indirect window with background transfers plus a direct bypass path.
// Optional feature macro: MDIO_BRIDGE_AUTOINC_EN (auto-increment of the indirect address on clean completion).
module mdio_apb_bridge #(
    parameter int                       REQ_AW     = 21,
    parameter int                       APB_AW     = 32,
    parameter int                       DW         = 16,
    parameter logic [REQ_AW-1:0]        WIN_BASE   = 21'h1F_FFFC,
    parameter logic [APB_AW-REQ_AW-1:0] BYP_PREFIX = 11'h001,
    parameter int                       TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [REQ_AW-1:0] mdio_req_paddr,
    input  logic              mdio_req_pwrite,
    input  logic              mdio_req_psel,
    input  logic              mdio_req_penable,
    input  logic [DW-1:0]     mdio_req_pwdata,
    output logic              mdio_req_pready,
    output logic [DW-1:0]     mdio_req_prdata,
    output logic              mdio_req_pslverr,
    output logic [APB_AW-1:0] apbmapper_paddr,
    output logic              apbmapper_pwrite,
    output logic              apbmapper_psel,
    output logic              apbmapper_penable,
    output logic [DW-1:0]     apbmapper_pwdata,
    input  logic              apbmapper_pready,
    input  logic [DW-1:0]     apbmapper_prdata,
    input  logic              apbmapper_pslverr
);
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WIN_RSP    = 3'd1,
        ST_IND_SETUP  = 3'd2,
        ST_IND_ACCESS = 3'd3,
        ST_BYP_SETUP  = 3'd4,
        ST_BYP_ACCESS = 3'd5,
        ST_BYP_RSP    = 3'd6
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t              state_r;
    logic [DW-1:0]       data_r, addr_h_r, addr_l_r;
    logic                wr_r, busy_r, to_err_r, slv_err_r, win_pend_r;
    logic [15:0]         timer_r;
    logic [APB_AW-1:0]   paddr_r;
    logic                pwrite_r, psel_r, penable_r, pready_r, pslverr_r;
    logic [DW-1:0]       pwdata_r, prdata_r;

    logic                req_vld_s, in_win_s, win_fire_s, ind_busy_s, inc_bit_s, timer_last_s;
    logic [REQ_AW-1:0]   off_s;
    logic [2*DW-1:0]     addr_cat_s;
    logic [APB_AW-1:0]   tgt_s;
    logic [DW-1:0]       ctrl_rd_s, win_rdata_s;

`ifdef MDIO_BRIDGE_AUTOINC_EN
    logic                inc_r;
    logic [2*DW-1:0]     addr_inc_s;
    assign inc_bit_s  = inc_r;
    assign addr_inc_s = addr_cat_s + {{(2*DW-1){1'b0}}, 1'b1};
`else
    assign inc_bit_s  = 1'b0;
`endif

    // The request stays asserted during its own pready cycle; ignore it there.
    assign req_vld_s    = mdio_req_psel & mdio_req_penable & ~pready_r;
    assign off_s        = mdio_req_paddr - WIN_BASE;
    assign in_win_s     = (off_s[REQ_AW-1:2] == {(REQ_AW-2){1'b0}});
    assign addr_cat_s   = {addr_h_r, addr_l_r};
    assign tgt_s        = addr_cat_s[APB_AW-1:0];
    assign ind_busy_s   = (state_r == ST_IND_SETUP) || (state_r == ST_IND_ACCESS);
    assign win_fire_s   = (state_r == ST_WIN_RSP) || win_pend_r;
    assign timer_last_s = (timer_r == TO_LAST);
    assign ctrl_rd_s    = {{(DW-6){1'b0}}, slv_err_r, to_err_r, busy_r, inc_bit_s, wr_r, 1'b0};

    // Window register read mux.
    always_comb begin
        win_rdata_s = data_r;
        case (off_s[1:0])
            2'd0:    win_rdata_s = data_r;
            2'd1:    win_rdata_s = addr_h_r;
            2'd2:    win_rdata_s = addr_l_r;
            2'd3:    win_rdata_s = ctrl_rd_s;
            default: win_rdata_s = data_r;
        endcase
    end

    // Main FSM, window registers and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            data_r     <= {DW{1'b0}};
            addr_h_r   <= {DW{1'b0}};
            addr_l_r   <= {DW{1'b0}};
            wr_r       <= 1'b0;
            busy_r     <= 1'b0;
            to_err_r   <= 1'b0;
            slv_err_r  <= 1'b0;
            win_pend_r <= 1'b0;
            timer_r    <= 16'd0;
            paddr_r    <= {APB_AW{1'b0}};
            pwrite_r   <= 1'b0;
            psel_r     <= 1'b0;
            penable_r  <= 1'b0;
            pwdata_r   <= {DW{1'b0}};
            pready_r   <= 1'b0;
            prdata_r   <= {DW{1'b0}};
            pslverr_r  <= 1'b0;
`ifdef MDIO_BRIDGE_AUTOINC_EN
            inc_r      <= 1'b0;
`endif
        end else begin
            pready_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (busy_r) begin
                        state_r   <= ST_IND_SETUP;
                        psel_r    <= 1'b1;
                        penable_r <= 1'b0;
                        paddr_r   <= tgt_s;
                        pwrite_r  <= wr_r;
                        pwdata_r  <= data_r;
                    end else if (req_vld_s && !win_pend_r) begin
                        if (in_win_s) begin
                            state_r <= ST_WIN_RSP;
                        end else begin
                            state_r   <= ST_BYP_SETUP;
                            psel_r    <= 1'b1;
                            penable_r <= 1'b0;
                            paddr_r   <= {BYP_PREFIX, mdio_req_paddr};
                            pwrite_r  <= mdio_req_pwrite;
                            pwdata_r  <= mdio_req_pwdata;
                        end
                    end
                end
                ST_WIN_RSP: state_r <= ST_IDLE;
                ST_IND_SETUP, ST_BYP_SETUP: begin
                    penable_r <= 1'b1;
                    timer_r   <= 16'd0;
                    state_r   <= (state_r == ST_IND_SETUP) ? ST_IND_ACCESS : ST_BYP_ACCESS;
                end
                ST_IND_ACCESS: begin
                    if (apbmapper_pready) begin
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                        if (!pwrite_r) begin
                            data_r <= apbmapper_prdata;
                        end
                        if (apbmapper_pslverr) begin
                            slv_err_r <= 1'b1;
                        end
`ifdef MDIO_BRIDGE_AUTOINC_EN
                        else if (inc_r) begin
                            {addr_h_r, addr_l_r} <= addr_inc_s;
                        end
`endif
                    end else if (timer_last_s) begin
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                        busy_r    <= 1'b0;
                        to_err_r  <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        timer_r <= timer_r + 16'd1;
                    end
                end
                ST_BYP_ACCESS: begin
                    if (apbmapper_pready || timer_last_s) begin
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                        pready_r  <= 1'b1;
                        prdata_r  <= apbmapper_pready ? apbmapper_prdata : {DW{1'b1}};
                        pslverr_r <= apbmapper_pready ? apbmapper_pslverr : 1'b1;
                        state_r   <= ST_BYP_RSP;
                    end else begin
                        timer_r <= timer_r + 16'd1;
                    end
                end
                ST_BYP_RSP: state_r <= ST_IDLE;
                default:    state_r <= ST_IDLE;
            endcase

            // Window accesses arriving during indirect work are answered one cycle later.
            if (win_fire_s) begin
                win_pend_r <= 1'b0;
            end else if (ind_busy_s && req_vld_s && in_win_s) begin
                win_pend_r <= 1'b1;
            end

            if (win_fire_s) begin
                pready_r  <= 1'b1;
                prdata_r  <= win_rdata_s;
                pslverr_r <= mdio_req_pwrite & busy_r;
                if (mdio_req_pwrite && !busy_r) begin
                    case (off_s[1:0])
                        2'd0: data_r   <= mdio_req_pwdata;
                        2'd1: addr_h_r <= mdio_req_pwdata;
                        2'd2: addr_l_r <= mdio_req_pwdata;
                        2'd3: begin
                            wr_r <= mdio_req_pwdata[1];
`ifdef MDIO_BRIDGE_AUTOINC_EN
                            inc_r <= mdio_req_pwdata[2];
`endif
                            if (mdio_req_pwdata[4]) to_err_r  <= 1'b0;
                            if (mdio_req_pwdata[5]) slv_err_r <= 1'b0;
                            if (mdio_req_pwdata[0]) busy_r    <= 1'b1;
                        end
                        default: data_r <= data_r;
                    endcase
                end
            end
        end
    end

    assign mdio_req_pready   = pready_r;
    assign mdio_req_prdata   = prdata_r;
    assign mdio_req_pslverr  = pslverr_r;
    assign apbmapper_paddr   = paddr_r;
    assign apbmapper_pwrite  = pwrite_r;
    assign apbmapper_psel    = psel_r;
    assign apbmapper_penable = penable_r;
    assign apbmapper_pwdata  = pwdata_r;
endmodule

// File: tb/tb_mdio_apb_bridge.sv
// Directed self-checking bench for mdio_apb_bridge (TIMEOUT=8); upstream requests and the
// apbmapper responder are driven from one initial block, forking where they overlap.
module tb_mdio_apb_bridge;
    localparam logic [20:0] WB  = 21'h1F_FFFC;
    localparam logic [20:0] BYA = 21'h00_0010;

    logic        clk = 1'b0;
    logic        rstn;
    logic [20:0] req_paddr;
    logic        req_pwrite, req_psel, req_penable;
    logic [15:0] req_pwdata;
    logic        req_pready;
    logic [15:0] req_prdata;
    logic        req_pslverr;
    logic [31:0] apb_paddr;
    logic        apb_pwrite, apb_psel, apb_penable;
    logic [15:0] apb_pwdata;
    logic        apb_pready;
    logic [15:0] apb_prdata;
    logic        apb_pslverr;

    int total = 0;
    int bad   = 0;

    mdio_apb_bridge #(.TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn),
        .mdio_req_paddr(req_paddr), .mdio_req_pwrite(req_pwrite), .mdio_req_psel(req_psel),
        .mdio_req_penable(req_penable), .mdio_req_pwdata(req_pwdata), .mdio_req_pready(req_pready),
        .mdio_req_prdata(req_prdata), .mdio_req_pslverr(req_pslverr),
        .apbmapper_paddr(apb_paddr), .apbmapper_pwrite(apb_pwrite), .apbmapper_psel(apb_psel),
        .apbmapper_penable(apb_penable), .apbmapper_pwdata(apb_pwdata), .apbmapper_pready(apb_pready),
        .apbmapper_prdata(apb_prdata), .apbmapper_pslverr(apb_pslverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Upstream transfer: psel&penable together, held until pready, then one idle cycle.
    task automatic xfer(input logic [20:0] a, input logic w, input logic [15:0] d,
                        output logic [15:0] rd, output logic er, output int lat);
        int n = 0;
        req_paddr = a; req_pwrite = w; req_pwdata = d; req_psel = 1'b1; req_penable = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_pready && n < 100);
        chk("xfer_done", req_pready, 1);
        rd = req_prdata; er = req_pslverr; lat = n;
        req_psel = 1'b0; req_penable = 1'b0;
        @(negedge clk);
    endtask

    // apbmapper responder: pready on the lat-th access cycle.
    task automatic serve(input int lat, input logic [15:0] rdat, input logic er,
                         output logic [31:0] a, output logic w, output logic [15:0] wd, output logic su);
        int n = 0;
        int k = 0;
        su = 1'b0;
        while (n < lat && k < 200) begin
            @(negedge clk);
            k++;
            if (apb_psel && !apb_penable) su = 1'b1;
            if (apb_psel && apb_penable) n++;
        end
        a = apb_paddr; w = apb_pwrite; wd = apb_pwdata;
        apb_prdata = rdat; apb_pslverr = er; apb_pready = 1'b1;
        @(negedge clk);
        apb_pready = 1'b0; apb_prdata = 16'h0000; apb_pslverr = 1'b0;
        chk("serve_seen", n, lat);
    endtask

    // Silent responder: counts access cycles until the bridge drops psel.
    task automatic hang(output int acc);
        int k = 0;
        acc = 0;
        while (k < 60 && !(acc > 0 && !apb_psel)) begin
            @(negedge clk);
            k++;
            if (apb_psel && apb_penable) acc++;
        end
    endtask

    initial begin
        logic [15:0] rd, rd2;
        logic        er, er2, w, su;
        int          lat, lat2, acc;
        logic [31:0] a;
        logic [15:0] wd;

        rstn = 1'b0; req_paddr = 21'd0; req_pwrite = 1'b0; req_psel = 1'b0; req_penable = 1'b0;
        req_pwdata = 16'h0000; apb_pready = 1'b0; apb_prdata = 16'h0000; apb_pslverr = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_paddr", apb_paddr, 32'h0000_0000);
        chk("rst_ctl", {apb_psel, apb_penable, apb_pwrite, req_pready, req_pslverr}, 32'd0);
        chk("rst_data", {apb_pwdata, req_prdata}, 32'd0);
        xfer(WB + 21'd3, 1'b0, 16'h0000, rd, er, lat);
        chk("rst_ctrl_reg", rd, 16'h0000);
        chk("win_latency", lat, 2);
        chk("win_rd_err", er, 1'b0);

        // Indirect write
        xfer(WB + 21'd1, 1'b1, 16'h0000, rd, er, lat);
        xfer(WB + 21'd2, 1'b1, 16'h1234, rd, er, lat);
        xfer(WB + 21'd0, 1'b1, 16'hBEEF, rd, er, lat);
        chk("win_wr_err", er, 1'b0);
        fork
            begin
                xfer(WB + 21'd3, 1'b1, 16'h0003, rd, er, lat);
                xfer(WB + 21'd3, 1'b0, 16'h0000, rd2, er2, lat2);
            end
            serve(3, 16'h0000, 1'b0, a, w, wd, su);
        join
        chk("go_err", er, 1'b0);
        chk("busy_ctrl", rd2, 16'h000A);
        chk("busy_rd_lat", lat2, 2);
        chk("ind_wr_addr", a, 32'h0000_1234);
        chk("ind_wr_dir", w, 1'b1);
        chk("ind_wr_data", wd, 16'hBEEF);
        chk("ind_setup_phase", su, 1'b1);
        xfer(WB + 21'd3, 1'b0, 16'h0000, rd, er, lat);
        chk("idle_ctrl", rd, 16'h0002);

        // Indirect read
        fork
            xfer(WB + 21'd3, 1'b1, 16'h0001, rd, er, lat);
            serve(3, 16'h5A5A, 1'b0, a, w, wd, su);
        join
        chk("ind_rd_dir", w, 1'b0);
        chk("ind_rd_addr", a, 32'h0000_1234);
        xfer(WB + 21'd0, 1'b0, 16'h0000, rd, er, lat);
        chk("ind_rd_data", rd, 16'h5A5A);
        xfer(WB + 21'd3, 1'b0, 16'h0000, rd, er, lat);
        chk("ind_rd_ctrl", rd, 16'h0000);

        // Bypass read
        fork
            xfer(BYA, 1'b0, 16'h0000, rd, er, lat);
            serve(1, 16'hCAFE, 1'b0, a, w, wd, su);
        join
        chk("byp_data", rd, 16'hCAFE);
        chk("byp_err", er, 1'b0);
        chk("byp_lat", lat, 3);
        chk("byp_addr", a, 32'h0020_0010);
        chk("byp_pulse", req_pready, 1'b0);

        // Bypass stalled behind an indirect read
        fork
            begin
                xfer(WB + 21'd3, 1'b1, 16'h0001, rd, er, lat);
                xfer(BYA, 1'b0, 16'h0000, rd2, er2, lat2);
            end
            begin
                serve(6, 16'h1111, 1'b0, a, w, wd, su);
                serve(1, 16'h7777, 1'b0, a, w, wd, su);
            end
        join
        chk("stall_data", rd2, 16'h7777);
        chk("stall_err", er2, 1'b0);
        chk("stall_lat", lat2, 10);
        chk("stall_addr", a, 32'h0020_0010);
        xfer(WB + 21'd0, 1'b0, 16'h0000, rd, er, lat);
        chk("stall_ind_data", rd, 16'h1111);

        // Bypass timeout
        fork
            xfer(BYA, 1'b0, 16'h0000, rd, er, lat);
            hang(acc);
        join
        chk("byp_to_data", rd, 16'hFFFF);
        chk("byp_to_err", er, 1'b1);
        chk("byp_to_lat", lat, 10);
        chk("byp_to_cycles", acc, 8);

        // Indirect timeout, with a rejected write and an allowed read while busy
        fork
            begin
                xfer(WB + 21'd3, 1'b1, 16'h0001, rd, er, lat);
                xfer(WB + 21'd2, 1'b1, 16'hAAAA, rd, er2, lat);
                xfer(WB + 21'd3, 1'b0, 16'h0000, rd2, er, lat);
            end
            hang(acc);
        join
        chk("busy_wr_err", er2, 1'b1);
        chk("busy_rd_ctrl", rd2, 16'h0008);
        chk("busy_rd_err", er, 1'b0);
        chk("ind_to_cycles", acc, 8);
        xfer(WB + 21'd3, 1'b0, 16'h0000, rd, er, lat);
        chk("ind_to_ctrl", rd, 16'h0010);
        xfer(WB + 21'd0, 1'b0, 16'h0000, rd, er, lat);
        chk("ind_to_data", rd, 16'h1111);
        xfer(WB + 21'd2, 1'b0, 16'h0000, rd, er, lat);
        chk("busy_wr_ignored", rd, 16'h1234);
        xfer(WB + 21'd3, 1'b1, 16'h0010, rd, er, lat);
        xfer(WB + 21'd3, 1'b0, 16'h0000, rd, er, lat);
        chk("to_err_w1c", rd, 16'h0000);

        // Address auto-increment
        xfer(WB + 21'd2, 1'b1, 16'hFFFF, rd, er, lat);
        xfer(WB + 21'd1, 1'b1, 16'h0000, rd, er, lat);
        fork
            xfer(WB + 21'd3, 1'b1, 16'h0007, rd, er, lat);
            serve(1, 16'h0000, 1'b0, a, w, wd, su);
        join
        chk("inc_xfer_addr", a, 32'h0000_FFFF);
        xfer(WB + 21'd1, 1'b0, 16'h0000, rd, er, lat);
        xfer(WB + 21'd2, 1'b0, 16'h0000, rd2, er, lat);
`ifdef MDIO_BRIDGE_AUTOINC_EN
        chk("inc_addr_h", rd, 16'h0001);
        chk("inc_addr_l", rd2, 16'h0000);
        xfer(WB + 21'd3, 1'b0, 16'h0000, rd, er, lat);
        chk("inc_ctrl", rd, 16'h0006);
`else
        chk("noinc_addr_h", rd, 16'h0000);
        chk("noinc_addr_l", rd2, 16'hFFFF);
        xfer(WB + 21'd3, 1'b0, 16'h0000, rd, er, lat);
        chk("noinc_ctrl", rd, 16'h0002);
`endif

        // Asynchronous reset in the middle of a bypass access
        req_paddr = BYA; req_pwrite = 1'b0; req_psel = 1'b1; req_penable = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_access", {apb_psel, apb_penable}, 2'b11);
        #2 rstn = 1'b0;
        #1 chk("async_rst_apb", {apb_psel, apb_penable, req_pready}, 3'b000);
        req_psel = 1'b0; req_penable = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        xfer(WB + 21'd2, 1'b0, 16'h0000, rd, er, lat);
        chk("rst_addr_l", rd, 16'h0000);
        xfer(WB + 21'd3, 1'b0, 16'h0000, rd, er, lat);
        chk("rst_ctrl_after", rd, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdio_apb_bridge.md
Name: mdio_apb_bridge

Overview:
Parametrised successor to the MDIO 22/45 request converter. Sits between the MDIO slave front-end (APB-like request port) and the apbmapper. It provides:
- a 4-register indirect window for wide-address APB accesses, run as background transactions;
- a direct bypass path for all other addresses;
- correct two-phase APB mastering and a per-transfer timeout.
Adds busy/error status, bypass stalling behind indirect work and optional address auto-increment.

Parameters:
REQ_AW, 21, request address width.
APB_AW, 32, apbmapper address width; must satisfy APB_AW <= 2*DW.
DW, 16, data width on both sides.
WIN_BASE, 21'h1F_FFFC, address of window reg 0; window occupies WIN_BASE..WIN_BASE+3.
BYP_PREFIX, 11'h001, upper APB_AW-REQ_AW bits prepended to bypass addresses.
TIMEOUT, 1024, access-phase cycles before abort; legal range 2..65535.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
mdio_req_paddr  in  REQ_AW  request address
mdio_req_pwrite  in  1  1=write
mdio_req_psel  in  1  select
mdio_req_penable  in  1  enable; psel&penable = request valid, held until pready
mdio_req_pwdata  in  DW  write data
mdio_req_pready  out  1  one-cycle completion pulse
mdio_req_prdata  out  DW  read data, valid with pready
mdio_req_pslverr  out  1  error, valid with pready
apbmapper_paddr  out  APB_AW  APB address
apbmapper_pwrite  out  1  APB write
apbmapper_psel  out  1  APB select
apbmapper_penable  out  1  APB enable
apbmapper_pwdata  out  DW  APB write data
apbmapper_pready  in  1  APB ready
apbmapper_prdata  in  DW  APB read data
apbmapper_pslverr  in  1  APB error

Behaviour:
- Reset: all outputs 0, window regs 0, FSM IDLE, timer 0. All outputs are registered.
- Window registers (offset from WIN_BASE):
  - +0 DATA: indirect write data / captured read data.
  - +1 ADDR_H.
  - +2 ADDR_L; target address = {ADDR_H,ADDR_L}[APB_AW-1:0].
  - +3 CTRL:
    - b0 GO (self-clearing, reads 0)
    - b1 WR
    - b2 INC
    - b3 BUSY (RO)
    - b4 TO_ERR (sticky, W1C)
    - b5 SLV_ERR (sticky, W1C)
    - others RO 0.
- Window access: pready pulses 2 cycles after psel&penable rises, pslverr=0.
  - Write while BUSY: no register change, pslverr=1.
  - Read while BUSY: allowed. Reading DATA while BUSY returns the stale value.
- GO write (CTRL write with b0=1, not BUSY): upstream completes normally and BUSY sets that cycle. Next cycle IND_SETUP (psel=1, penable=0), then IND_ACCESS (psel=1, penable=1) until apbmapper_pready.
  - Completion of a read latches prdata into DATA.
  - apbmapper_pslverr sets SLV_ERR.
  - BUSY clears on completion.
- Bypass (psel&penable, address outside window):
  - If BUSY, stall: pready held 0 until the indirect transfer ends, then run.
  - BYP_SETUP → BYP_ACCESS, paddr = {BYP_PREFIX, mdio_req_paddr}.
  - Upstream pready pulses the cycle after apbmapper_pready, carrying the registered prdata and pslverr.
- FSM: IDLE, WIN_RSP, IND_SETUP, IND_ACCESS, BYP_SETUP, BYP_ACCESS, BYP_RSP.
  - Priority in IDLE: pending GO > upstream request.
  - Upstream window accesses are served during IND_* via a separate response path; one window response is outstanding at most.
- Timeout: counter runs only in *_ACCESS and clears on entry.
  - At TIMEOUT cycles without pready: drop psel/penable.
  - Indirect abort: sets TO_ERR, clears BUSY; DATA is unchanged.
  - Bypass abort: responds with pready=1, pslverr=1, prdata={DW{1'b1}}.
- Same-cycle apbmapper_pready and timeout expiry: pready wins, no error.
- Reset asserted mid-transfer: immediate return to the reset state; APB outputs deassert asynchronously.

Optional Feature:
MDIO_BRIDGE_AUTOINC_EN:
- Defined: when CTRL.INC=1 and an indirect transfer completes without error, {ADDR_H,ADDR_L} increments by 1 with wrap at 2^(2*DW). The increment is not applied on timeout or slverr.
- Undefined: INC bit is RO 0 and the address never changes.

Test Plan:
- Write ADDR_H=16'h0000, ADDR_L=16'h1234, DATA=16'hBEEF, CTRL=16'h0003 → single APB write: paddr=32'h0000_1234, pwdata=16'hBEEF, psel then penable; BUSY reads 1 until pready, then 0.
- Indirect read with CTRL=16'h0001, apbmapper_prdata=16'h5A5A, pready after 3 cycles → DATA reads 16'h5A5A, TO_ERR=0.
- Bypass read at 21'h00_0010 → paddr=32'h0020_0010; apbmapper_prdata=16'hCAFE returned with a one-cycle pready pulse.
- Bypass issued while an indirect transfer is pending (apbmapper_pready withheld 10 cycles) → upstream pready stays 0 until the indirect transfer finishes; the bypass then completes with correct data.
- TIMEOUT=8, apbmapper_pready never asserted:
  - bypass → pready with pslverr=1, prdata=16'hFFFF after 8 access cycles;
  - indirect → CTRL reads 16'h0010; writing 16'h0010 clears it.
- With MDIO_BRIDGE_AUTOINC_EN defined, ADDR_L=16'hFFFF, ADDR_H=16'h0000, CTRL=16'h0007 → after completion ADDR_H=16'h0001, ADDR_L=16'h0000.
